// File: rtl/mixer_pkg.sv
// Shared audio-path helpers: constant clog2, unity gain and saturating narrow.
package mixer_pkg;

  localparam int unsigned SAT_MAX_W = 64;

  typedef struct packed {
    logic [SAT_MAX_W-1:0] value;
    logic                 clip;
  } sat_t;

  // Ceiling log2, minimum 1 so single-bit indices stay legal.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) r = 32'(i + 1);
    end
    return r;
  endfunction

  // Unity in unsigned Q1.(gain_w-1).
  function automatic int unsigned unity_gain(input int unsigned gain_w);
    return 32'd1 << (gain_w - 1);
  endfunction

  // Clamp a wide signed value to out_w bits; value is sign-extended to SAT_MAX_W.
  function automatic sat_t sat_narrow_f(input logic signed [SAT_MAX_W-1:0] x,
                                        input int unsigned out_w);
    sat_t r;
    logic signed [SAT_MAX_W-1:0] maxv;
    logic signed [SAT_MAX_W-1:0] minv;
    maxv = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    minv = -(64'sd1 <<< (out_w - 1));
    if (x > maxv) begin
      r.value = maxv;
      r.clip  = 1'b1;
    end else if (x < minv) begin
      r.value = minv;
      r.clip  = 1'b1;
    end else begin
      r.value = x;
      r.clip  = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_narrow.sv
// Combinational signed saturating narrow from IN_W to OUT_W bits (IN_W > OUT_W).
module sat_narrow #(
  parameter int unsigned IN_W  = 37,
  parameter int unsigned OUT_W = 24
) (
  input  logic signed [IN_W-1:0]  in_i,
  output logic signed [OUT_W-1:0] value_o,
  output logic                    clip_o
);

  localparam int unsigned TOP_W = IN_W - OUT_W + 1;

  logic [TOP_W-1:0] top_c;
  logic             sign_c;

  assign top_c  = in_i[IN_W-1:OUT_W-1];
  assign sign_c = in_i[IN_W-1];

  // In range only when every bit above the output sign matches the input sign.
  always_comb begin
    clip_o  = (top_c != {TOP_W{sign_c}});
    value_o = in_i[OUT_W-1:0];
    if (clip_o) begin
      value_o = sign_c ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/voice_mixer.sv
// N-voice time-multiplexed mixer: per-voice gain, wide accumulation, output clip.
module voice_mixer
  import mixer_pkg::*;
#(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned NUM_VOICES = 10,
  parameter int unsigned GAIN_W     = 8,
  parameter int unsigned MIX_SHIFT  = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clk_en,
  input  logic signed [DATA_W-1:0]         i_data,
  input  logic                             i_sync,
  input  logic                             i_gain_we,
  input  logic [clog2(NUM_VOICES)-1:0]     i_gain_addr,
  input  logic [GAIN_W-1:0]                i_gain_data,
  output logic signed [DATA_W-1:0]         o_mixed,
  output logic                             o_valid,
  output logic                             o_clip
);

  localparam int unsigned IDX_W  = clog2(NUM_VOICES);
  localparam int unsigned PROD_W = DATA_W + GAIN_W + 1;
  localparam int unsigned ACC_W  = PROD_W + IDX_W;
  localparam int unsigned SHIFT  = GAIN_W - 1 + MIX_SHIFT;
  localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(unity_gain(GAIN_W));
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(NUM_VOICES - 1);

  logic [GAIN_W-1:0]        gain_q [NUM_VOICES];
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic signed [DATA_W-1:0] mixed_q, mixed_d;
  logic                     clip_q, clip_d;
  logic                     valid_q, valid_d;

  logic [GAIN_W-1:0]        gain_sel_c;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [ACC_W-1:0]  sum_c;
  logic signed [ACC_W-1:0]  scaled_c;
  logic signed [DATA_W-1:0] sat_val_c;
  logic                     sat_clip_c;

  assign gain_sel_c = gain_q[idx_q];
  assign prod_c     = PROD_W'(i_data) * PROD_W'($signed({1'b0, gain_sel_c}));
  assign sum_c      = acc_q + ACC_W'(prod_c);
  assign scaled_c   = sum_c >>> SHIFT;

  sat_narrow #(
    .IN_W  (ACC_W),
    .OUT_W (DATA_W)
  ) u_sat (
    .in_i    (scaled_c),
    .value_o (sat_val_c),
    .clip_o  (sat_clip_c)
  );

  // Gain bank; the read above sees the pre-write value on a same-edge write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_VOICES); i++) gain_q[i] <= UNITY;
    end else if (i_gain_we && (32'(i_gain_addr) < NUM_VOICES)) begin
      gain_q[i_gain_addr] <= i_gain_data;
    end
  end

  // Slot sequencing: resync restarts the frame, last slot emits the mix.
  always_comb begin
    acc_d   = acc_q;
    idx_d   = idx_q;
    mixed_d = mixed_q;
    clip_d  = clip_q;
    valid_d = 1'b0;
    if (clk_en) begin
      if (i_sync && (idx_q != '0)) begin
        acc_d = ACC_W'(prod_c);
        idx_d = IDX_W'(1);
      end else if (idx_q == LAST) begin
        mixed_d = sat_val_c;
        clip_d  = sat_clip_c;
        valid_d = 1'b1;
        acc_d   = '0;
        idx_d   = '0;
      end else begin
        acc_d = sum_c;
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      idx_q   <= '0;
      mixed_q <= '0;
      clip_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      mixed_q <= mixed_d;
      clip_q  <= clip_d;
      valid_q <= valid_d;
    end
  end

  assign o_mixed = mixed_q;
  assign o_clip  = clip_q;
  assign o_valid = valid_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer at default parameters.
module tb_voice_mixer;

  logic               clk = 1'b0;
  logic               rst;
  logic               clk_en;
  logic signed [23:0] i_data;
  logic               i_sync;
  logic               i_gain_we;
  logic [3:0]         i_gain_addr;
  logic [7:0]         i_gain_data;
  logic signed [23:0] o_mixed;
  logic               o_valid;
  logic               o_clip;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cnt = 0;

  voice_mixer dut (
    .clk         (clk),
    .rst         (rst),
    .clk_en      (clk_en),
    .i_data      (i_data),
    .i_sync      (i_sync),
    .i_gain_we   (i_gain_we),
    .i_gain_addr (i_gain_addr),
    .i_gain_data (i_gain_data),
    .o_mixed     (o_mixed),
    .o_valid     (o_valid),
    .o_clip      (o_clip)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (o_valid === 1'b1) valid_cnt++;
  endtask

  task automatic sample(input logic signed [23:0] d, input logic s);
    clk_en = 1'b1;
    i_data = d;
    i_sync = s;
    tick();
    i_sync = 1'b0;
  endtask

  task automatic frame(input logic signed [23:0] d);
    for (int i = 0; i < 10; i++) sample(d, 1'b0);
  endtask

  task automatic write_gain(input logic [3:0] a, input logic [7:0] g);
    clk_en      = 1'b0;
    i_gain_we   = 1'b1;
    i_gain_addr = a;
    i_gain_data = g;
    tick();
    i_gain_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clk_en = 1'b0; i_data = '0; i_sync = 1'b0;
    i_gain_we = 1'b0; i_gain_addr = '0; i_gain_data = '0;
    repeat (3) tick();
    n_checks++;
    if ({o_mixed, o_valid, o_clip} !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_state: got mixed=%0d valid=%b clip=%b, want 0/0/0", o_mixed, o_valid, o_clip);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_unity_back_to_back();
    valid_cnt = 0;
    frame(24'sd1000);
    n_checks++;
    if (o_valid !== 1'b1 || o_mixed !== 24'sd10000 || o_clip !== 1'b0) begin
      n_fail++;
      $display("FAIL unity_sum: got valid=%b mixed=%0d clip=%b, want 1/10000/0", o_valid, o_mixed, o_clip);
    end
    valid_cnt = 0;
    frame(24'sd2000);
    n_checks++;
    if (o_valid !== 1'b1 || o_mixed !== 24'sd20000 || valid_cnt != 1) begin
      n_fail++;
      $display("FAIL back_to_back: got valid=%b mixed=%0d pulses=%0d, want 1/20000/1", o_valid, o_mixed, valid_cnt);
    end
    clk_en = 1'b0;
    tick();
    n_checks++;
    if (o_valid !== 1'b0 || o_mixed !== 24'sd20000) begin
      n_fail++;
      $display("FAIL valid_width: got valid=%b mixed=%0d, want 0/20000", o_valid, o_mixed);
    end
  endtask

  task automatic test_saturation();
    frame(24'sh7FFFFF);
    n_checks++;
    if (o_mixed !== 24'sh7FFFFF || o_clip !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_pos: got mixed=%h clip=%b, want 7fffff/1", o_mixed, o_clip);
    end
    frame(24'sh800000);
    n_checks++;
    if (o_mixed !== 24'sh800000 || o_clip !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_neg: got mixed=%h clip=%b, want 800000/1", o_mixed, o_clip);
    end
    clk_en = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (o_clip !== 1'b1 || o_mixed !== 24'sh800000) begin
      n_fail++;
      $display("FAIL clip_hold: got mixed=%h clip=%b, want 800000/1", o_mixed, o_clip);
    end
    frame(24'sd0);
    n_checks++;
    if (o_mixed !== 24'sd0 || o_clip !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_clear: got mixed=%0d clip=%b, want 0/0", o_mixed, o_clip);
    end
  endtask

  task automatic test_gain();
    for (int a = 10; a < 16; a++) write_gain(4'(a), 8'd0);
    frame(24'sd1000);
    n_checks++;
    if (o_mixed !== 24'sd10000) begin
      n_fail++;
      $display("FAIL gain_oob_ignored: got %0d, want 10000", o_mixed);
    end
    write_gain(4'd3, 8'd0);
    write_gain(4'd5, 8'd64);
    frame(24'sd1000);
    n_checks++;
    if (o_mixed !== 24'sd8500) begin
      n_fail++;
      $display("FAIL gain_per_voice: got %0d, want 8500", o_mixed);
    end
    i_gain_we = 1'b1; i_gain_addr = 4'd0; i_gain_data = 8'd0;
    sample(24'sd1000, 1'b0);
    i_gain_we = 1'b0;
    for (int i = 1; i < 10; i++) sample(24'sd1000, 1'b0);
    n_checks++;
    if (o_mixed !== 24'sd8500) begin
      n_fail++;
      $display("FAIL gain_same_edge: got %0d, want 8500", o_mixed);
    end
    frame(24'sd1000);
    n_checks++;
    if (o_mixed !== 24'sd7500) begin
      n_fail++;
      $display("FAIL gain_applied: got %0d, want 7500", o_mixed);
    end
    write_gain(4'd0, 8'd128);
    write_gain(4'd3, 8'd128);
    write_gain(4'd5, 8'd128);
  endtask

  task automatic test_sparse();
    frame(24'sd5);
    clk_en = 1'b0;
    tick();
    valid_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      sample(24'sd1000, 1'b0);
      if (i == 9) begin
        n_checks++;
        if (o_valid !== 1'b1 || o_mixed !== 24'sd10000) begin
          n_fail++;
          $display("FAIL sparse_result: got valid=%b mixed=%0d, want 1/10000", o_valid, o_mixed);
        end
      end else if (i == 4) begin
        n_checks++;
        if (o_mixed !== 24'sd50) begin
          n_fail++;
          $display("FAIL sparse_hold_mid: got %0d, want 50", o_mixed);
        end
      end
      clk_en = 1'b0;
      i_data = 24'sh123456;
      tick();
      tick();
    end
    n_checks++;
    if (o_mixed !== 24'sd10000 || o_valid !== 1'b0 || valid_cnt != 1) begin
      n_fail++;
      $display("FAIL sparse_pulse: got mixed=%0d valid=%b pulses=%0d, want 10000/0/1", o_mixed, o_valid, valid_cnt);
    end
  endtask

  task automatic test_resync();
    valid_cnt = 0;
    for (int i = 0; i < 4; i++) sample(24'sd500, 1'b0);
    sample(24'sd200, 1'b1);
    for (int i = 0; i < 8; i++) sample(24'sd100, 1'b0);
    n_checks++;
    if (valid_cnt != 0) begin
      n_fail++;
      $display("FAIL resync_no_valid: got %0d pulses, want 0", valid_cnt);
    end
    sample(24'sd100, 1'b0);
    n_checks++;
    if (o_valid !== 1'b1 || o_mixed !== 24'sd1100) begin
      n_fail++;
      $display("FAIL resync_sum: got valid=%b mixed=%0d, want 1/1100", o_valid, o_mixed);
    end
    sample(24'sd100, 1'b1);
    for (int i = 1; i < 10; i++) sample(24'sd100, 1'b0);
    n_checks++;
    if (o_mixed !== 24'sd1000) begin
      n_fail++;
      $display("FAIL sync_at_zero: got %0d, want 1000", o_mixed);
    end
  endtask

  task automatic test_reset_mid_frame();
    frame(24'sh7FFFFF);
    for (int i = 0; i < 5; i++) sample(24'sd1000, 1'b0);
    rst = 1'b1;
    clk_en = 1'b1;
    tick();
    n_checks++;
    if ({o_mixed, o_valid, o_clip} !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got mixed=%0d valid=%b clip=%b, want 0/0/0", o_mixed, o_valid, o_clip);
    end
    rst = 1'b0;
    frame(24'sd10);
    n_checks++;
    if (o_valid !== 1'b1 || o_mixed !== 24'sd100) begin
      n_fail++;
      $display("FAIL reset_recover: got valid=%b mixed=%0d, want 1/100", o_valid, o_mixed);
    end
    clk_en = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_unity_back_to_back();
    test_saturation();
    test_gain();
    test_sparse();
    test_resync();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/voice_mixer.md
# voice_mixer

Parametrised N-voice time-multiplexed mixer with per-voice gain, full-precision accumulation and output saturation. It sits between the voice generators and the output DAC/codec path. It accepts one voice sample per enabled clock and emits one mixed sample per frame with a valid strobe. It replaces the fixed 10-voice, shift-by-4 mixer: headroom is handled by a wide accumulator plus a clip detector instead of pre-scaling.

## Interface
- DATA_W, 24: sample width, signed two's complement.
- NUM_VOICES, 10: voices per frame, ≥2.
- GAIN_W, 8: gain width, unsigned Q1.(GAIN_W-1); unity = 2^(GAIN_W-1).
- MIX_SHIFT, 0: extra arithmetic right shift applied to the frame sum before saturation.

- clk  in  1  system clock; one clock domain; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- clk_en  in  1  sample strobe; i_data and i_sync are consumed only when high.
- i_data  in  DATA_W  signed voice sample for the current voice slot.
- i_sync  in  1  qualified by clk_en; marks i_data as voice 0.
- i_gain_we  in  1  gain write enable; independent of clk_en.
- i_gain_addr  in  clog2(NUM_VOICES)  voice index to write.
- i_gain_data  in  GAIN_W  new gain value.
- o_mixed  out  DATA_W  signed saturated frame mix; held between frames.
- o_valid  out  1  one-clk pulse when o_mixed updates.
- o_clip  out  1  set with o_valid when the frame saturated; held until the next frame.

## Operation
- Gain bank: NUM_VOICES registers, reset to unity. Writes to out-of-range addresses are ignored.
- Product per sample: i_data × signed({0,gain}), at width DATA_W+GAIN_W+1.
- Accumulator: ACC_W = DATA_W+GAIN_W+1+clog2(NUM_VOICES). It never wraps.
- On each clk_en, the accepted sample is voice v_idx (0..NUM_VOICES-1).
- Normal slot (v_idx < NUM_VOICES-1): acc ← acc + product; v_idx ← v_idx+1.
- Last slot (v_idx = NUM_VOICES-1):
  - sum = acc + product.
  - scaled = sum >>> (GAIN_W-1+MIX_SHIFT). This is floor, with no rounding.
  - o_mixed ← saturate(scaled) to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - o_clip ← 1 if saturation occurred, else 0.
  - acc ← 0; v_idx ← 0.
- Resync: clk_en & i_sync with v_idx ≠ 0 discards the partial frame. acc ← product; v_idx ← 1; no o_valid. With v_idx = 0, i_sync has no effect.
- clk_en low: v_idx, acc, o_mixed and o_clip hold.
- Gain write and a sample of the same voice on the same edge: the sample uses the old gain, and the new gain applies from the next edge.
- Reset: o_mixed = 0, o_valid = 0, o_clip = 0, acc = 0, v_idx = 0, all gains = unity. This holds mid-frame; the partial frame is lost.

## Timing
- Multiply-accumulate is single-cycle, with no pipeline.
- Output timing: o_mixed and o_clip register on the same edge that accepts the last voice sample. o_valid is high for exactly the following clk period, whether or not clk_en is high in that period.
- Minimum clk_en spacing is 1 (clk_en may be held high continuously). Back-to-back frames then give o_valid once every NUM_VOICES clocks.
- rst has priority over clk_en, i_sync and gain writes.

## Structure
- Shared package mixer_pkg:
  - clog2 function
  - UNITY_GAIN(GAIN_W) constant
  - saturating-narrow function (ACC_W→DATA_W, returns value + clip flag)

  Other audio-path blocks also use this package.
- One sub-module: sat_narrow (combinational, parameters IN_W/OUT_W; outputs value and clip). The gain bank and the accumulator stay in voice_mixer.

## Test plan
Defaults: DATA_W=24, NUM_VOICES=10, GAIN_W=8, MIX_SHIFT=0.
- Unity gain sum: unity gains, ten samples of 1000 with clk_en held high → o_mixed = 10000; o_valid is 1 for one clk; o_clip = 0.
- Saturation: ten samples of 0x7FFFFF → o_mixed = 0x7FFFFF, o_clip = 1. Ten samples of -8388608 → o_mixed = -8388608, o_clip = 1. Next frame of zeros → o_mixed = 0, o_clip = 0.
- Per-voice gain: gain[3] = 0, gain[5] = 64, other voices unity, all samples 1000 → o_mixed = 8500. Same-edge write of gain[0] = 0 while voice 0 is sampled → that frame still uses unity for voice 0.
- Sparse clk_en: clk_en high every 3rd clk, same data as the unity gain case → o_mixed = 10000 after 30 clks; outputs hold between strobes; o_valid is one clk wide.
- Resync: four samples of 500, then i_sync with sample 200, then nine samples of 100 → no o_valid for the aborted frame; o_mixed = 1100.
- Reset mid-frame: rst after five samples of 1000 → all outputs 0 the next clk. Then ten samples of 10 → o_mixed = 100.
